topk_stream_sort: RTL and testbench
===================================

TOPK_STREAM_SORT -- requirements
Module: topk_stream_sort

Interface
REQ-001 SHALL have parameter K, default 8: number of nearest neighbours retained, K >= 2.
REQ-002 SHALL have parameter W, default 16: distance width in bits.
REQ-003 SHALL have parameter TYPE_W, default 4: class/type label width in bits.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: clear list and begin a new query.
REQ-007 SHALL have port in_valid, input, 1: sample present.
REQ-008 SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-009 SHALL have ports in_dist (input, W) and in_type (input, TYPE_W): sample distance and label.
REQ-010 SHALL have port in_last, input, 1: final sample of the query, qualified by the accept.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-013 SHALL have ports out_dist[0:K-1] (output, W each) and out_type[0:K-1] (output, TYPE_W each): ascending list, index 0 nearest.
REQ-014 SHALL have port out_count, output, $clog2(K+1): number of occupied slots.
REQ-015 SHALL have, with KNN_VOTE_EN defined only, port out_class, output, TYPE_W: majority label.

Function
REQ-016 SHALL implement states IDLE, COLLECT, VOTE, HOLD.
REQ-017 IDLE: in_ready=0, out_valid=0; start -> clear all slot valid bits, count=0, go COLLECT.
REQ-018 COLLECT: in_ready=1; each accepted sample SHALL be compared against all K slots in the same cycle.
REQ-019 Insertion SHALL place the sample at the lowest index whose slot is empty or holds strictly greater distance; entries at and above shift up one; slot K-1 content is discarded.
REQ-020 Equal distances SHALL keep arrival order (earlier sample at lower index); a sample not less than a full list's slot K-1 SHALL be dropped.
REQ-021 out_count SHALL saturate at K.
REQ-022 Accepted in_last SHALL move COLLECT -> VOTE (macro defined) or -> HOLD (undefined); the in_last sample is inserted first.
REQ-023 HOLD: out_valid=1, outputs stable; out_ready -> IDLE in the same cycle out_valid is observed with out_ready.
REQ-024 Latency: out_valid SHALL rise 1 cycle after the last accept without the macro, K+1 cycles with it.
REQ-025 start in COLLECT SHALL abort: slots cleared, remain COLLECT, the same-cycle sample ignored.
REQ-026 start in VOTE or HOLD SHALL be ignored.
REQ-027 Unoccupied slots SHALL output distance 0 and type 0.
REQ-028 in_last with zero prior samples SHALL produce out_count=1.

Reset
REQ-029 rst SHALL force state IDLE, all slots invalid, out_count=0, out_dist/out_type=0, in_ready=0, out_valid=0, out_class=0, vote counters 0; rst has priority over all inputs, including mid-COLLECT and mid-VOTE.

Configuration
REQ-030 Macro KNN_VOTE_EN defined: VOTE state SHALL scan one occupied slot per cycle for K cycles, increment a per-label counter ($clog2(K+1) bits, 2**TYPE_W counters), and load out_class with the highest count; ties SHALL resolve to the smaller label value.
REQ-031 Macro KNN_VOTE_EN undefined: VOTE state, counters and out_class port SHALL be absent; behaviour otherwise identical.

Structure
REQ-032 Package knn_pkg SHALL hold the state enum type and default K/W/TYPE_W constants shared with the distance blocks.
REQ-033 Sub-module topk_slot SHALL implement one slot: register, strict-less compare, shift/insert mux; instantiated K times.

Verification
REQ-034 K=4: distances 9,3,7,1,5 (last) -> out_dist 1,3,5,7, out_count=4, out_valid 1 cycle after last.
REQ-035 K=4: (5,A),(5,B),(5,C) last -> out_type A,B,C, out_count=3, slot 3 zero.
REQ-036 out_ready held 0 for 10 cycles -> outputs and out_valid stable; in_ready=0 throughout.
REQ-037 start after 2 samples, then 8 (last) -> out_dist[0]=8, out_count=1.
REQ-038 KNN_VOTE_EN, K=4: types 2,5,5,2 -> out_class=2 (tie, smaller); types 3,3,1,0 -> 3; out_valid at last+5.
REQ-039 rst asserted mid-COLLECT -> next cycle IDLE, out_count=0, in_ready=0.

Source files
------------

// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : knn_pkg
//  Purpose  : Shared FSM state type and default sizing for the k-NN blocks.
//  Revision : 1.0  initial release
// ============================================================================
package knn_pkg;

  localparam int c_k_default      = 8;
  localparam int c_w_default      = 16;
  localparam int c_type_w_default = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_HOLD    = 2'd3
  } knn_state_t;

endpackage
`default_nettype wire

// File: rtl/topk_slot.sv
`default_nettype none
// ============================================================================
//  Module   : topk_slot
//  Purpose  : One entry of the sorted top-K list: register, strict-less
//             compare against the incoming sample, and shift/insert select.
//  Revision : 1.0  initial release
// ============================================================================
module topk_slot
  import knn_pkg::*;
#(
  parameter int W      = c_w_default,
  parameter int TYPE_W = c_type_w_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ins_en,
  input  logic              prev_less,
  input  logic              prev_valid,
  input  logic [W-1:0]      prev_dist,
  input  logic [TYPE_W-1:0] prev_type,
  input  logic [W-1:0]      in_dist,
  input  logic [TYPE_W-1:0] in_type,
  output logic              less,
  output logic              slot_valid,
  output logic [W-1:0]      slot_dist,
  output logic [TYPE_W-1:0] slot_type
);

  logic              r_valid;
  logic [W-1:0]      r_dist;
  logic [TYPE_W-1:0] r_type;

  // Strict compare keeps equal distances in arrival order.
  assign less = !r_valid || (in_dist < r_dist);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_valid <= 1'b0;
      r_dist  <= '0;
      r_type  <= '0;
    end else if (ins_en && less) begin
      if (prev_less) begin
        r_valid <= prev_valid;
        r_dist  <= prev_dist;
        r_type  <= prev_type;
      end else begin
        r_valid <= 1'b1;
        r_dist  <= in_dist;
        r_type  <= in_type;
      end
    end
  end

  assign slot_valid = r_valid;
  assign slot_dist  = r_dist;
  assign slot_type  = r_type;

endmodule
`default_nettype wire

// File: rtl/topk_stream_sort.sv
`default_nettype none
// ============================================================================
//  Module   : topk_stream_sort
//  Purpose  : Streaming K-nearest list; one sample per cycle inserted in
//             sorted order. Define KNN_VOTE_EN to add a majority-label vote.
//  Revision : 1.0  initial release
// ============================================================================
module topk_stream_sort
  import knn_pkg::*;
#(
  parameter int K      = c_k_default,
  parameter int W      = c_w_default,
  parameter int TYPE_W = c_type_w_default
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_dist,
  input  logic [TYPE_W-1:0]      in_type,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_dist [0:K-1],
  output logic [TYPE_W-1:0]      out_type [0:K-1],
  output logic [$clog2(K+1)-1:0] out_count
`ifdef KNN_VOTE_EN
  ,
  output logic [TYPE_W-1:0]      out_class
`endif
);

  localparam int c_cnt_w = $clog2(K+1);

  knn_state_t         r_state;
  knn_state_t         w_state_nxt;
  logic               w_clear;
  logic               w_ins_en;
  logic [c_cnt_w-1:0] r_count;
  logic [K-1:0]       w_less;
  logic [K-1:0]       w_valid;
  logic [K-1:0]       w_prev_less;
  logic [K-1:0]       w_prev_valid;
  logic [W-1:0]       w_dist      [0:K-1];
  logic [TYPE_W-1:0]  w_type      [0:K-1];
  logic [W-1:0]       w_prev_dist [0:K-1];
  logic [TYPE_W-1:0]  w_prev_type [0:K-1];
`ifdef KNN_VOTE_EN
  logic               w_vote_done;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (!start && in_valid && in_last)
`ifdef KNN_VOTE_EN
                    w_state_nxt = ST_VOTE;
      ST_VOTE:    if (w_vote_done) w_state_nxt = ST_HOLD;
`else
                    w_state_nxt = ST_HOLD;
`endif
      ST_HOLD:    if (out_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // start during COLLECT aborts the query and discards that cycle's sample.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_clear   = 1'b0;
    w_ins_en  = 1'b0;
    case (r_state)
      ST_IDLE:    w_clear = start;
      ST_COLLECT: begin
        in_ready = 1'b1;
        w_clear  = start;
        w_ins_en = in_valid && !start;
      end
      ST_HOLD:    out_valid = 1'b1;
      default:    ;
    endcase
  end

  // The list stays sorted, so any insertion point implies the last slot compares less.
  always_ff @(posedge clk) begin
    if (rst || w_clear)
      r_count <= '0;
    else if (w_ins_en && w_less[K-1] && (r_count != c_cnt_w'(K)))
      r_count <= r_count + 1'b1;
  end

  assign out_count    = r_count;
  assign w_prev_less  = {w_less[K-2:0], 1'b0};
  assign w_prev_valid = {w_valid[K-2:0], 1'b0};

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign w_prev_dist[i] = '0;
      assign w_prev_type[i] = '0;
    end else begin : g_link
      assign w_prev_dist[i] = w_dist[i-1];
      assign w_prev_type[i] = w_type[i-1];
    end

    topk_slot #(
      .W      (W),
      .TYPE_W (TYPE_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clear      (w_clear),
      .ins_en     (w_ins_en),
      .prev_less  (w_prev_less[i]),
      .prev_valid (w_prev_valid[i]),
      .prev_dist  (w_prev_dist[i]),
      .prev_type  (w_prev_type[i]),
      .in_dist    (in_dist),
      .in_type    (in_type),
      .less       (w_less[i]),
      .slot_valid (w_valid[i]),
      .slot_dist  (w_dist[i]),
      .slot_type  (w_type[i])
    );

    assign out_dist[i] = w_valid[i] ? w_dist[i] : '0;
    assign out_type[i] = w_valid[i] ? w_type[i] : '0;
  end

`ifdef KNN_VOTE_EN
  localparam int c_labels = 2**TYPE_W;
  localparam int c_scan_w = $clog2(K);

  logic [c_scan_w-1:0] r_scan;
  logic [c_cnt_w-1:0]  r_votes     [0:c_labels-1];
  logic [c_cnt_w-1:0]  w_votes_nxt [0:c_labels-1];
  logic [c_cnt_w-1:0]  w_best_cnt;
  logic [TYPE_W-1:0]   w_best;
  logic [TYPE_W-1:0]   r_class;
  logic                w_hit;

  assign w_vote_done = (r_scan == c_scan_w'(K-1));
  assign w_hit       = w_valid[r_scan];

  // Winner includes the slot scanned this cycle so the result lands with the last count.
  always_comb begin
    for (int l = 0; l < c_labels; l++)
      w_votes_nxt[l] = r_votes[l] +
        ((w_hit && (w_type[r_scan] == TYPE_W'(l))) ? c_cnt_w'(1) : c_cnt_w'(0));
    w_best     = '0;
    w_best_cnt = w_votes_nxt[0];
    for (int l = 1; l < c_labels; l++) begin
      if (w_votes_nxt[l] > w_best_cnt) begin
        w_best     = TYPE_W'(l);
        w_best_cnt = w_votes_nxt[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan  <= '0;
      r_class <= '0;
      for (int l = 0; l < c_labels; l++) r_votes[l] <= '0;
    end else if (r_state == ST_VOTE) begin
      r_scan <= r_scan + 1'b1;
      for (int l = 0; l < c_labels; l++) r_votes[l] <= w_votes_nxt[l];
      if (w_vote_done) begin
        r_scan  <= '0;
        r_class <= w_best;
      end
    end else begin
      r_scan <= '0;
      for (int l = 0; l < c_labels; l++) r_votes[l] <= '0;
    end
  end

  assign out_class = r_class;
`endif

endmodule
`default_nettype wire

// File: tb/tb_topk_stream_sort.sv
`default_nettype none
// ============================================================================
//  Module   : tb_topk_stream_sort
//  Purpose  : Scoreboard bench for topk_stream_sort (K=4) with a sorted-list
//             reference model; honours KNN_VOTE_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_topk_stream_sort;

  localparam int K  = 4;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int CW = $clog2(K+1);
`ifdef KNN_VOTE_EN
  localparam int LAT = K + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [K-1:0][W-1:0]  d;
    logic [K-1:0][TW-1:0] t;
    logic [CW-1:0]        cnt;
    logic [TW-1:0]        cls;
    logic [31:0]          vcyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_dist = '0;
  logic [TW-1:0] in_type = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_dist [0:K-1];
  logic [TW-1:0] out_type [0:K-1];
  logic [CW-1:0] out_count;
`ifdef KNN_VOTE_EN
  logic [TW-1:0] out_class;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall = 0;
  bit   rand_rdy = 0;
  bit   have_cur = 0;
  bit   prev_v = 0;
  bit   prev_r = 0;
  exp_t cur;
  exp_t sb [$];
  logic [W-1:0]  mdl_d [$];
  logic [TW-1:0] mdl_t [$];

  topk_stream_sort #(.K(K), .W(W), .TYPE_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dist   (in_dist),
    .in_type   (in_type),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_type  (out_type),
    .out_count (out_count)
`ifdef KNN_VOTE_EN
    ,
    .out_class (out_class)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall = stall - 1;
    end else begin
      out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Reference: the K smallest distances, earliest arrival first among equals.
  function automatic exp_t build(input int acc);
    exp_t e;
    bit   used [0:63];
    int   votes [0:15];
    int   n, best, bc;
    e = '0;
    n = mdl_d.size();
    for (int i = 0; i < 64; i++) used[i] = 1'b0;
    for (int l = 0; l < 16; l++) votes[l] = 0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || mdl_d[i] < mdl_d[best])) best = i;
      if (best >= 0) begin
        used[best] = 1'b1;
        e.d[r] = mdl_d[best];
        e.t[r] = mdl_t[best];
        e.cnt  = e.cnt + 1'b1;
        votes[mdl_t[best]]++;
      end
    end
    bc = 0;
    for (int l = 1; l < 16; l++) if (votes[l] > votes[bc]) bc = l;
    e.cls  = TW'(bc);
    e.vcyc = 32'(acc + LAT);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
      prev_v   = 1'b0;
      prev_r   = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        checks++;
        if (!out_valid) begin
          errors++;
          $display("FAIL valid_drop out_valid=0 expected=1 at cycle %0d", cyc);
        end
      end
      if (out_valid) begin
        if (!have_cur) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result out_valid=1 expected no result at cycle %0d", cyc);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            checks++;
            if (32'(cyc) !== cur.vcyc) begin
              errors++;
              $display("FAIL latency valid_cycle=%0d expected=%0d", cyc, cur.vcyc);
            end
          end
        end
        if (have_cur) begin
          for (int r = 0; r < K; r++) begin
            checks++;
            if (out_dist[r] !== cur.d[r] || out_type[r] !== cur.t[r]) begin
              errors++;
              $display("FAIL slot%0d dist=%0d type=%0d expected dist=%0d type=%0d",
                       r, out_dist[r], out_type[r], cur.d[r], cur.t[r]);
            end
          end
          checks++;
          if (out_count !== cur.cnt) begin
            errors++;
            $display("FAIL out_count got=%0d expected=%0d", out_count, cur.cnt);
          end
`ifdef KNN_VOTE_EN
          checks++;
          if (out_class !== cur.cls) begin
            errors++;
            $display("FAIL out_class got=%0d expected=%0d", out_class, cur.cls);
          end
`endif
          if (out_ready) have_cur = 1'b0;
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_in_hold got=%0b expected=0", in_ready);
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_start(input bit junk);
    start    = 1'b1;
    in_valid = junk;
    in_last  = junk;
    in_dist  = 16'd99;
    in_type  = 4'd9;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mdl_d.delete();
    mdl_t.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input bit last);
    int g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_collect", int'(in_ready), 1);
    in_valid = 1'b1;
    in_dist  = d;
    in_type  = t;
    in_last  = last;
    mdl_d.push_back(d);
    mdl_t.push_back(t);
    if (last) sb.push_back(build(cyc));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while ((sb.size() != 0 || have_cur || out_valid) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", g >= 400 ? 1 : 0, 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_dist0", int'(out_dist[0]), 0);
    chk("rst_out_type3", int'(out_type[3]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 0);

    do_start(0);
    send(16'd9, 4'd1, 0); send(16'd3, 4'd2, 0); send(16'd7, 4'd3, 0);
    send(16'd1, 4'd4, 0); send(16'd5, 4'd5, 1);
    wait_done();

    do_start(0);
    send(16'd5, 4'd10, 0); send(16'd5, 4'd11, 0); send(16'd5, 4'd12, 1);
    wait_done();

    do_start(0);
    send(16'd4, 4'd1, 0); send(16'd6, 4'd2, 0);
    do_start(1);
    send(16'd8, 4'd3, 1);
    wait_done();

    do_start(0);
    send(16'd77, 4'd6, 1);
    wait_done();

    // Result held back for many cycles while start is pulsed (ignored).
    do_start(0);
    send(16'd12, 4'd7, 0);
    stall = 24;
    send(16'd2, 4'd8, 1);
    start = 1'b1;
    repeat (8) @(negedge clk);
    start = 1'b0;
    wait_done();

    do_start(0);
    send(16'd10, 4'd2, 0); send(16'd20, 4'd5, 0);
    send(16'd30, 4'd5, 0); send(16'd40, 4'd2, 1);
    wait_done();

    do_start(0);
    send(16'd10, 4'd3, 0); send(16'd20, 4'd3, 0);
    send(16'd30, 4'd1, 0); send(16'd40, 4'd0, 1);
    wait_done();

    do_start(0);
    send(16'd3, 4'd1, 0); send(16'd4, 4'd2, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_count", int'(out_count), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_dist0", int'(out_dist[0]), 0);
    rst = 1'b0;
    mdl_d.delete();
    mdl_t.delete();
    @(negedge clk);

    rand_rdy = 1'b1;
    for (int q = 0; q < 40; q++) begin
      do_start($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (i > 0 && $urandom_range(0, 9) == 0) do_start(1);
        send(W'($urandom_range(0, 20)), TW'($urandom_range(0, 15)), i == n - 1);
      end
      wait_done();
    end
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
